// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Alarm-system state machine producing the 8-bit front-panel status word.
// Runs the exit delay after arming, the entry delay when the door zone trips
// while armed, and a strobe pattern shown on the LEDs while arming and while
// the alarm is triggered.
//
// Optional feature (compile-time macro ALARM_AUTO_REARM_EN):
//   When defined, TRIGGERED returns to ARMED once the siren hold time has
//   elapsed with all zones clear. When undefined, TRIGGERED is left only by
//   arm_key or reset.
//
// Ports:
//   iCLK       in   1  system clock
//   iRST       in   1  asynchronous, active-high reset
//   tick       in   1  one-cycle 100 ms enable pulse
//   panic_key  in   1  one-cycle debounced panic pulse
//   arm_key    in   1  one-cycle debounced arm/disarm toggle pulse
//   zone       in   3  zone sensor levels, 1 = tripped; zone[0] is the door
//   led        out  8  registered status word
//   state      out  3  current state code
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int EXIT_TICKS   = 100,
  parameter int ENTRY_TICKS  = 50,
  parameter int STROBE_TICKS = 2,
  parameter int SIREN_TICKS  = 600,
  parameter int TW           = 10
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       tick,
  input  logic       panic_key,
  input  logic       arm_key,
  input  logic [2:0] zone,
  output logic [7:0] led,
  output logic [2:0] state
);

  localparam logic [2:0] ST_DISARMED      = 3'd0;
  localparam logic [2:0] ST_ARM_PENDING   = 3'd1;
  localparam logic [2:0] ST_ARMED         = 3'd2;
  localparam logic [2:0] ST_ENTRY_PENDING = 3'd3;
  localparam logic [2:0] ST_TRIGGERED     = 3'd4;

  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam logic [TW-1:0] EXIT_LAST   = TW'(EXIT_TICKS - 1);
  localparam logic [TW-1:0] ENTRY_LAST  = TW'(ENTRY_TICKS - 1);
  localparam logic [TW-1:0] STROBE_LAST = TW'(STROBE_TICKS - 1);
`ifdef ALARM_AUTO_REARM_EN
  localparam logic [TW-1:0] SIREN_LAST  = TW'(SIREN_TICKS - 1);
`endif

  // Every tick count has to fit the counter width, otherwise the delay
  // comparisons would silently wrap.
  if (EXIT_TICKS < 1 || EXIT_TICKS > 2**TW - 1) begin : g_bad_exit
    $error("alarm_controller: EXIT_TICKS does not fit in TW bits");
  end
  if (ENTRY_TICKS < 1 || ENTRY_TICKS > 2**TW - 1) begin : g_bad_entry
    $error("alarm_controller: ENTRY_TICKS does not fit in TW bits");
  end
  if (STROBE_TICKS < 1 || STROBE_TICKS > 2**TW - 1) begin : g_bad_strobe
    $error("alarm_controller: STROBE_TICKS does not fit in TW bits");
  end
  if (SIREN_TICKS < 1 || SIREN_TICKS > 2**TW - 1) begin : g_bad_siren
    $error("alarm_controller: SIREN_TICKS does not fit in TW bits");
  end

  logic [2:0]    next_state;
  logic          state_change;
  logic [TW-1:0] timer;
  logic [TW-1:0] strobe_div;
  logic          strobe;
  logic [2:0]    trig_zone;

  // Next-state logic. Illegal codes fall straight back to DISARMED; after
  // that panic beats arm_key, and arm_key beats every zone/timer event.
  always_comb begin
    next_state = state;
    if (state > ST_TRIGGERED) begin
      next_state = ST_DISARMED;
    end else if (panic_key) begin
      next_state = ST_TRIGGERED;
    end else begin
      case (state)
        ST_DISARMED: begin
          if (arm_key && zone == 3'b000)
            next_state = ST_ARM_PENDING;
        end
        ST_ARM_PENDING: begin
          if (arm_key)
            next_state = ST_DISARMED;
          else if (tick && timer == EXIT_LAST)
            next_state = (zone == 3'b000) ? ST_ARMED : ST_DISARMED;
        end
        ST_ARMED: begin
          if (arm_key)
            next_state = ST_DISARMED;
          else if (zone[2:1] != 2'b00)
            next_state = ST_TRIGGERED;
          else if (zone[0])
            next_state = ST_ENTRY_PENDING;
        end
        ST_ENTRY_PENDING: begin
          if (arm_key)
            next_state = ST_DISARMED;
          else if (zone[2:1] != 2'b00)
            next_state = ST_TRIGGERED;
          else if (tick && timer == ENTRY_LAST)
            next_state = ST_TRIGGERED;
        end
        ST_TRIGGERED: begin
          if (arm_key)
            next_state = ST_DISARMED;
`ifdef ALARM_AUTO_REARM_EN
          // The timer saturates rather than wrapping, so a zone held tripped
          // past the hold time re-arms on the first clear tick afterwards.
          else if (tick && timer >= SIREN_LAST && zone == 3'b000)
            next_state = ST_ARMED;
`endif
        end
        default: next_state = ST_DISARMED;
      endcase
    end
  end

  // A panic while already triggered is treated as a fresh entry so the
  // delay/siren timer restarts even though the state code does not change.
  assign state_change = (next_state != state) || panic_key;

  // State register and the per-state tick timer.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_DISARMED;
      timer <= '0;
    end else begin
      state <= next_state;
      if (state_change)
        timer <= '0;
      else if (tick && timer != TIMER_MAX)
        timer <= timer + 1'b1;
    end
  end

  // Remembers every zone seen while triggered so the panel keeps showing the
  // cause after the sensor itself goes quiet.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      trig_zone <= 3'b000;
    end else if (next_state == ST_TRIGGERED) begin
      trig_zone <= (state == ST_TRIGGERED) ? (trig_zone | zone) : zone;
    end else begin
      trig_zone <= 3'b000;
    end
  end

  // Strobe generator. It only runs while arming or triggered; ENTRY_PENDING
  // can only be reached from ARMED, so holding there keeps it at zero.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      strobe_div <= '0;
      strobe     <= 1'b0;
    end else begin
      case (state)
        ST_ARM_PENDING, ST_TRIGGERED: begin
          if (tick) begin
            if (strobe_div == STROBE_LAST) begin
              strobe_div <= '0;
              strobe     <= ~strobe;
            end else begin
              strobe_div <= strobe_div + 1'b1;
            end
          end
        end
        ST_ENTRY_PENDING: begin
          strobe_div <= strobe_div;
          strobe     <= strobe;
        end
        default: begin
          strobe_div <= '0;
          strobe     <= 1'b0;
        end
      endcase
    end
  end

  // LED word is registered from the already-updated state, so it trails the
  // state code by one clock. led[5] is a spare and always reads 0.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      led <= 8'h80;
    end else begin
      case (state)
        ST_DISARMED:      led <= {1'b1, 2'b00, zone, 2'b00};
        ST_ARM_PENDING:   led <= {1'b0, strobe, 6'b000000};
        ST_ARMED:         led <= 8'h40;
        ST_ENTRY_PENDING: led <= {2'b01, 1'b0, zone, 2'b00};
        ST_TRIGGERED:     led <= {2'b01, 1'b0, trig_zone, strobe, 1'b1};
        default:          led <= 8'h80;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_controller
//
// Self-checking bench for alarm_controller. A tick-counting reference model
// predicts state and led every clock; directed steps walk through arming,
// entry delay, zone trips, panic and the siren hold, then a random phase
// mixes keys, ticks and zone changes.
// -----------------------------------------------------------------------------
module tb_alarm_controller;

  localparam int EXIT_TICKS   = 100;
  localparam int ENTRY_TICKS  = 50;
  localparam int STROBE_TICKS = 2;
  localparam int SIREN_TICKS  = 600;
  localparam int TW           = 10;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       tick;
  logic       panic_key;
  logic       arm_key;
  logic [2:0] zone;
  logic [7:0] led;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: state number, ticks spent in the current state, ticks
  // spent with the strobe running, latched trip zones, predicted led.
  int         mState;
  int         mTicks;
  int         mRunTicks;
  logic [2:0] mTrig;
  logic [7:0] mLed;

  alarm_controller #(
    .EXIT_TICKS  (EXIT_TICKS),
    .ENTRY_TICKS (ENTRY_TICKS),
    .STROBE_TICKS(STROBE_TICKS),
    .SIREN_TICKS (SIREN_TICKS),
    .TW          (TW)
  ) dut (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .tick     (tick),
    .panic_key(panic_key),
    .arm_key  (arm_key),
    .zone     (zone),
    .led      (led),
    .state    (state)
  );

  always #5 iCLK = ~iCLK;

  // Panel word for a given state; the strobe is the parity of how many whole
  // half-periods of ticks have elapsed while the strobe was running.
  function automatic logic [7:0] ledFor(int st, logic [2:0] z, logic [2:0] tz, int rt);
    logic s;
    s = ((rt / STROBE_TICKS) % 2) == 1;
    case (st)
      0:       return {1'b1, 2'b00, z, 2'b00};
      1:       return {1'b0, s, 6'b000000};
      2:       return 8'h40;
      3:       return {2'b01, 1'b0, z, 2'b00};
      4:       return {2'b01, 1'b0, tz, s, 1'b1};
      default: return 8'h80;
    endcase
  endfunction

  // Advances the model across one clock edge with the given inputs.
  task automatic modelStep(input logic tk, input logic pk, input logic ak, input logic [2:0] z);
    int nxt;
    nxt  = mState;
    mLed = ledFor(mState, z, mTrig, mRunTicks);
    if (pk) begin
      nxt = 4;
    end else begin
      case (mState)
        0: if (ak && z == 3'b000) nxt = 1;
        1: begin
          if (ak) nxt = 0;
          else if (tk && mTicks + 1 == EXIT_TICKS) nxt = (z == 3'b000) ? 2 : 0;
        end
        2: begin
          if (ak) nxt = 0;
          else if (z[2] || z[1]) nxt = 4;
          else if (z[0]) nxt = 3;
        end
        3: begin
          if (ak) nxt = 0;
          else if (z[2] || z[1]) nxt = 4;
          else if (tk && mTicks + 1 == ENTRY_TICKS) nxt = 4;
        end
        4: begin
          if (ak) nxt = 0;
`ifdef ALARM_AUTO_REARM_EN
          else if (tk && mTicks + 1 >= SIREN_TICKS && z == 3'b000) nxt = 2;
`endif
        end
        default: nxt = 0;
      endcase
    end
    if (mState == 1 || mState == 4) begin
      if (tk) mRunTicks++;
    end else if (mState != 3) begin
      mRunTicks = 0;
    end
    if (nxt == 4) mTrig = (mState == 4) ? (mTrig | z) : z;
    else          mTrig = 3'b000;
    if (nxt != mState || pk) mTicks = 0;
    else if (tk)             mTicks++;
    mState = nxt;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one clock of inputs away from the edge, then checks #1 after it.
  task automatic applyStimulus(input logic tk, input logic pk, input logic ak, input logic [2:0] z);
    @(negedge iCLK);
    tick      = tk;
    panic_key = pk;
    arm_key   = ak;
    zone      = z;
    modelStep(tk, pk, ak, z);
    @(posedge iCLK);
    #1;
    checkOutput("state", {5'b00000, state}, 8'(mState));
    checkOutput("led", led, mLed);
  endtask

  task automatic tickN(input int n, input logic [2:0] z);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, z);
      applyStimulus(1'b0, 1'b0, 1'b0, z);
    end
  endtask

  initial begin
    logic [2:0] rz;
    iRST      = 1'b1;
    tick      = 1'b0;
    panic_key = 1'b0;
    arm_key   = 1'b0;
    zone      = 3'b010;
    mState    = 0;
    mTicks    = 0;
    mRunTicks = 0;
    mTrig     = 3'b000;
    mLed      = 8'h80;

    $display("[TB] reset");
    repeat (3) @(posedge iCLK);
    #1;
    checkOutput("rst_led", led, 8'h80);
    checkOutput("rst_state", {5'b00000, state}, 8'h00);
    @(negedge iCLK);
    iRST = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b010);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b010);
    checkOutput("rst_led88", led, 8'h88);

    $display("[TB] arm and exit delay");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
    checkOutput("arm_pending", {5'b00000, state}, 8'h01);
    tickN(2, 3'b000);
    checkOutput("ap_strobe_on", led, 8'h40);
    tickN(2, 3'b000);
    checkOutput("ap_strobe_off", led, 8'h00);
    tickN(95, 3'b000);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
    checkOutput("armed_state", {5'b00000, state}, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    checkOutput("armed_led", led, 8'h40);

    $display("[TB] entry delay");
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b001);
    checkOutput("entry_state", {5'b00000, state}, 8'h03);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b001);
    checkOutput("entry_led", led, 8'h44);
    tickN(49, 3'b001);
    checkOutput("entry_hold", {5'b00000, state}, 8'h03);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b001);
    checkOutput("entry_trig", {5'b00000, state}, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b001);
    checkOutput("trig_led", led, 8'h45);
    tickN(2, 3'b001);
    checkOutput("trig_strobe", led, 8'h47);

    $display("[TB] interior zone trip");
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
    checkOutput("disarm_trig", {5'b00000, state}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
    tickN(100, 3'b000);
    checkOutput("rearmed", {5'b00000, state}, 8'h02);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b100);
    checkOutput("zone2_trig", {5'b00000, state}, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
    checkOutput("disarm_state", {5'b00000, state}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    checkOutput("disarm_led", led, 8'h80);

    $display("[TB] panic with arm");
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
    checkOutput("panic_state", {5'b00000, state}, 8'h04);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
    checkOutput("panic_led", {7'b0000000, (led == 8'h41 || led == 8'h43)}, 8'h01);

    $display("[TB] siren hold");
    tickN(SIREN_TICKS, 3'b000);
`ifdef ALARM_AUTO_REARM_EN
    checkOutput("rearm_state", {5'b00000, state}, 8'h02);
    checkOutput("rearm_led", led, 8'h40);
`else
    tickN(400, 3'b000);
    checkOutput("no_rearm_state", {5'b00000, state}, 8'h04);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);

    $display("[TB] random phase");
    rz = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(29) == 0)
        rz = ($urandom_range(2) == 0) ? 3'($urandom_range(7)) : 3'b000;
      applyStimulus($urandom_range(1) == 1, $urandom_range(99) == 0,
                    $urandom_range(79) == 0, rz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
